spi_flash_responder: RTL and testbench
======================================

# spi_flash_responder

Read-only SPI flash target that answers the XIP read sequence issued by the SPI master in the peripheral subsystem. It samples the master's SCK/SS/MOSI pins in the system clock domain, decodes the 8-bit command and 24-bit address, and fetches 32-bit words from a backing memory port. It then shifts the data back MSB-first on MISO, auto-incrementing while SS stays asserted. It is used as the flash-side model in simulation and as the on-chip flash front end for SoC builds.

## Interface
- `ADDR_W`, default 24: width of the flash byte address and of `mem_addr`.
- `READ_CMD`, default 8'h03: the only command accepted.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `spi_sck`  in  1  SPI clock from the master, asynchronous to `clock`.
- `spi_ss`  in  1  chip select, active low.
- `spi_mosi`  in  1  master-to-target data.
- `spi_miso`  out  1  target-to-master data.
- `mem_req`  out  1  word fetch request; held until `mem_ack`.
- `mem_addr`  out  ADDR_W  byte address of the word, bits [1:0] forced 0.
- `mem_ack`  in  1  one-cycle pulse: `mem_rdata` valid.
- `mem_rdata`  in  32  fetched word, bit 31 shifted first.
- `busy`  out  1  high while in any state other than IDLE.
- `cmd_err`  out  1  sticky: an unsupported command was received.
- `underrun`  out  1  sticky: a data word was not available in time.

## Operation
- `spi_sck`, `spi_ss`, `spi_mosi` pass through 2-flop synchronisers. A third flop on SCK gives rise/fall pulses. SS is active when the synchronised value is 0.
- SPI mode 0: MOSI is sampled on SCK rise; MISO changes on SCK fall.
- States:
  - IDLE: SS active -> CMD with bit counter 0.
  - CMD: shift 8 MOSI bits on rises. If the byte equals READ_CMD, go to ADDR. Otherwise set `cmd_err` and go to IGNORE.
  - ADDR: shift 24 bits, MSB first. After the 24th rise, latch `{addr[23:2],2'b00}` into `mem_addr`, assert `mem_req`, and go to DATA.
  - DATA: on `mem_ack`, load `mem_rdata` into the tx shift register and drop `mem_req`. Each SCK fall drives the next bit on `spi_miso`, starting with bit 31.
    - After the 32nd bit is driven, `mem_addr` += 4 (wraps modulo 2^ADDR_W) and `mem_req` reasserts, fetching the next word.
  - IGNORE: `spi_miso` = 0; wait for SS inactive.
- SS inactive in any state -> IDLE next cycle. Counters clear, `mem_req` drops, and any late `mem_ack` is discarded. Sticky flags are kept.
- Underrun: if a word's first bit is due (SCK fall detected) and `mem_ack` has not arrived, set `underrun`. That word is sent as all zeros. The request stays pending, and its data, when acked, is dropped. The next word then proceeds normally.
- If `mem_ack` and an SCK fall occur in the same cycle, `mem_ack` wins: bit 31 of the new word is driven that cycle.
- Byte-address bits [1:0] from the command are ignored; reads are word aligned.

## Timing
- Reset (`reset`=0): state IDLE, `spi_miso`=0, `mem_req`=0, `mem_addr`=0, `busy`=0, `cmd_err`=0, `underrun`=0, and all synchronisers = idle (SS=1, SCK=0).
- Pin-to-decision latency: 3 `clock` cycles from an SCK/SS pin edge to the internal pulse.
- `spi_miso` updates 3 cycles after the SCK pin falls. The SCK half-period must be ≥ 5 `clock` cycles; the master divider of 0x10 satisfies this.
- `mem_req` rises the cycle after the 32nd rise pulse. `mem_ack` must arrive within one SCK half-period minus 4 cycles to avoid underrun.
- `mem_req`/`mem_ack`: request level-held. A single-cycle ack completes it, and `mem_addr` is stable while `mem_req` is high.
- Reset asserted mid-transfer aborts immediately (asynchronous). Operation resumes only on a fresh SS falling edge after reset release.

## Test plan
- Reset mid-DATA: all outputs return to reset values at once. A new SS cycle with cmd 0x03, addr 0x000000 returns the word at byte address 0x0.
- Master sends 0x03, 0x000100 with half-period 17 clocks; memory returns 0xDEADBEEF after 2 cycles -> MISO bits 32–63 = 0xDEADBEEF, `mem_addr`=0x000100, `underrun`=0.
- Keep SS low for 96 SCKs at addr 0xFFFFFC -> second word fetched from `mem_addr`=0x000000 (wrap).
- Command 0x0B -> `cmd_err`=1, no `mem_req`, MISO stays 0 until SS high, `busy` falls 1 cycle after SS high is synced.
- Memory acks 40 cycles late with half-period 17 -> first word all zeros, `underrun`=1. Second word correct.
- SS raised after 20 address bits -> IDLE, no `mem_req`. The next transaction decodes correctly from bit 0.

Source files
------------

// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   Read-only SPI flash target (mode 0). Decodes an 8-bit READ command and a
//   24-bit byte address from the master, then streams 32-bit words fetched
//   from a backing memory port MSB-first on MISO, auto-incrementing the word
//   address while SS stays low.
//
// Ports
//   clock, reset          system clock / async active-low reset
//   spi_sck/ss/mosi       master pins (asynchronous, synchronised inside)
//   spi_miso              target-to-master data, changes on SCK fall
//   mem_req/addr/ack/rdata  word fetch handshake (req held until ack)
//   busy                  not idle
//   cmd_err, underrun     sticky error flags, cleared only by reset
module spi_flash_responder #(
  parameter int unsigned ADDR_W   = 24,
  parameter logic [7:0]  READ_CMD = 8'h03
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_ss,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              cmd_err,
  output logic              underrun
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    IGNORE = 3'd4
  } state_e;

  // Pin synchronisers; the third SCK flop provides edge detection.
  logic [2:0] sck_q;
  logic [1:0] ss_q;
  logic [1:0] mosi_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sck_q  <= '0;
      ss_q   <= '1;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], spi_sck};
      ss_q   <= {ss_q[0], spi_ss};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  logic sck_rise, sck_fall, ss_act, mosi_bit;
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign ss_act   = ~ss_q[1];
  assign mosi_bit = mosi_q[1];

  state_e             state_q;
  logic [4:0]         bit_cnt_q;
  logic [23:0]        rx_sh_q;
  logic [31:0]        tx_sh_q;
  logic               loaded_q;   // tx_sh_q holds a fresh word awaiting its first fall
  logic               drop_q;     // outstanding request belongs to an underrun word
  logic               next_due_q; // next fetch deferred behind a dropped request
  logic               miso_q, req_q, busy_q, cmd_err_q, underrun_q;
  logic [ADDR_W-1:0]  addr_q;

  logic [23:0]        rx_next;
  logic [ADDR_W-1:0]  word_addr;
  logic [ADDR_W-1:0]  addr_inc;
  logic               ack_ok;

  assign rx_next   = {rx_sh_q[22:0], mosi_bit};
  assign word_addr = ADDR_W'(rx_next) & ~ADDR_W'(3);
  assign addr_inc  = addr_q + ADDR_W'(4);
  assign ack_ok    = mem_ack & req_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_sh_q    <= '0;
      tx_sh_q    <= '0;
      loaded_q   <= 1'b0;
      drop_q     <= 1'b0;
      next_due_q <= 1'b0;
      miso_q     <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else if (!ss_act) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      loaded_q   <= 1'b0;
      drop_q     <= 1'b0;
      next_due_q <= 1'b0;
      miso_q     <= 1'b0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q   <= CMD;
          bit_cnt_q <= '0;
          busy_q    <= 1'b1;
        end

        CMD: begin
          if (sck_rise) begin
            rx_sh_q <= rx_next;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_q <= '0;
              if (rx_next[7:0] == READ_CMD) begin
                state_q <= ADDR;
              end else begin
                cmd_err_q <= 1'b1;
                state_q   <= IGNORE;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end
        end

        ADDR: begin
          if (sck_rise) begin
            rx_sh_q <= rx_next;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_q  <= '0;
              addr_q     <= word_addr;
              req_q      <= 1'b1;
              loaded_q   <= 1'b0;
              drop_q     <= 1'b0;
              next_due_q <= 1'b0;
              state_q    <= DATA;
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end
        end

        DATA: begin
          // Memory side first; the SCK-fall handling below overrides where
          // both touch the same register in one cycle.
          if (ack_ok) begin
            if (drop_q) begin
              drop_q <= 1'b0;
              if (next_due_q) begin
                // Stale word retired; issue the deferred fetch back-to-back.
                addr_q     <= addr_inc;
                next_due_q <= 1'b0;
              end else begin
                req_q <= 1'b0;
              end
            end else begin
              req_q    <= 1'b0;
              tx_sh_q  <= mem_rdata;
              loaded_q <= 1'b1;
            end
          end

          if (sck_fall) begin
            if (bit_cnt_q == 5'd0 && ack_ok && !drop_q) begin
              miso_q   <= mem_rdata[31];
              tx_sh_q  <= {mem_rdata[30:0], 1'b0};
              loaded_q <= 1'b0;
            end else if (bit_cnt_q == 5'd0 && !loaded_q) begin
              // Word not ready: send zeros and discard its data when it lands.
              underrun_q <= 1'b1;
              miso_q     <= 1'b0;
              tx_sh_q    <= '0;
              drop_q     <= req_q;
            end else begin
              miso_q   <= tx_sh_q[31];
              tx_sh_q  <= {tx_sh_q[30:0], 1'b0};
              loaded_q <= 1'b0;
            end

            if (bit_cnt_q == 5'd31) begin
              bit_cnt_q <= '0;
              if (req_q && drop_q && !ack_ok) begin
                next_due_q <= 1'b1;
              end else begin
                addr_q <= addr_inc;
                req_q  <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end
        end

        IGNORE: begin
          miso_q <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign spi_miso = miso_q;
  assign mem_req  = req_q;
  assign mem_addr = addr_q;
  assign busy     = busy_q;
  assign cmd_err  = cmd_err_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: drives an SPI mode-0 master and a latency-
// programmable memory, and compares received words, fetch addresses and
// status flags against a word-addressed reference memory.
module tb_spi_flash_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_ss = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy, cmd_err, underrun;

  spi_flash_responder #(.ADDR_W(24), .READ_CMD(8'h03)) dut (
    .clock    (clock),
    .reset    (reset),
    .spi_sck  (spi_sck),
    .spi_ss   (spi_ss),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .cmd_err  (cmd_err),
    .underrun (underrun)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  int lat = 2;        // default ack latency in cycles
  int once_lat = 0;   // latency override for the next fetch only
  int wcnt = 0;
  int req_cycles = 0;
  logic [23:0] fetch_q[$];
  logic [31:0] rx_q[$];
  logic        pre_nz;
  logic [31:0] seed;
  logic        exp_cmd_err = 1'b0;
  logic        exp_underrun = 1'b0;

  function automatic logic [31:0] memf(input logic [23:0] a);
    if (a == 24'h000100) return 32'hDEADBEEF;
    return ({8'h00, a} * 32'h9E3779B1) ^ seed;
  endfunction

  // Memory responder: acks each request after the programmed latency.
  initial begin
    forever begin
      @(negedge clock);
      if (mem_req === 1'b1) req_cycles++;
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req === 1'b1) begin
        wcnt++;
        if (wcnt >= ((once_lat != 0) ? once_lat : lat)) begin
          mem_ack   = 1'b1;
          mem_rdata = memf(mem_addr);
          fetch_q.push_back(mem_addr);
          wcnt      = 0;
          once_lat  = 0;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One SS-low cycle: cmd, abits address bits, nwords data words.
  // reset_at >= 0 asserts reset right after that rise and aborts.
  task automatic spi_xfer(input logic [7:0] cmd, input logic [23:0] addr, input int abits,
                          input int nwords, input int h, input int reset_at);
    int total, dstart, j;
    logic [31:0] w;
    rx_q.delete();
    fetch_q.delete();
    req_cycles = 0;
    pre_nz = 1'b0;
    w = '0;
    dstart = 8 + abits;
    total = dstart + 32 * nwords;
    spi_ss = 1'b0;
    for (int i = 0; i < total; i++) begin
      if (i < 8) spi_mosi = cmd[7-i];
      else if (i < dstart) spi_mosi = addr[23-(i-8)];
      else spi_mosi = 1'($urandom_range(0, 1));
      repeat (h) @(negedge clock);
      spi_sck = 1'b1;
      if (i < dstart) begin
        pre_nz = pre_nz | spi_miso;
      end else begin
        j = i - dstart;
        w = {w[30:0], spi_miso};
        if (j % 32 == 31) rx_q.push_back(w);
      end
      if (i == reset_at) begin
        reset = 1'b0;
        #1;
        chk("reset_mid_outputs", 64'({spi_miso, mem_req, mem_addr, busy, cmd_err, underrun}), 64'(0));
        spi_ss  = 1'b1;
        spi_sck = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        return;
      end
      repeat (h) @(negedge clock);
      spi_sck = 1'b0;
    end
    repeat (h) @(negedge clock);
    spi_ss = 1'b1;
    repeat (2) @(negedge clock);
    chk("busy_until_ss_synced", 64'(busy), 64'(1));
    @(negedge clock);
    chk("busy_falls", 64'(busy), 64'(0));
    repeat (5) @(negedge clock);
  endtask

  task automatic check_read(input string tag, input logic [23:0] addr, input int nwords,
                            input logic first_ur);
    logic [23:0] a0;
    logic [23:0] ak;
    logic [31:0] ew;
    a0 = addr & 24'hFFFFFC;
    exp_underrun = exp_underrun | first_ur;
    chk({tag, "_pre_miso"}, 64'(pre_nz), 64'(0));
    chk({tag, "_nwords"}, 64'(rx_q.size()), 64'(nwords));
    for (int k = 0; k < nwords; k++) begin
      ak = a0 + 24'(4 * k);
      ew = (first_ur && k == 0) ? 32'h0 : memf(ak);
      chk($sformatf("%s_word%0d", tag, k), 64'(rx_q[k]), 64'(ew));
    end
    chk({tag, "_nfetch"}, 64'(fetch_q.size()), 64'(nwords + 1));
    for (int k = 0; k <= nwords; k++) begin
      ak = a0 + 24'(4 * k);
      chk($sformatf("%s_faddr%0d", tag, k), 64'(fetch_q[k]), 64'(ak));
    end
    chk({tag, "_underrun"}, 64'(underrun), 64'(exp_underrun));
    chk({tag, "_cmd_err"}, 64'(cmd_err), 64'(exp_cmd_err));
    chk({tag, "_req_idle"}, 64'(mem_req), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (observed hang, required completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] ra;
    int nw, h;
    seed = $urandom;

    // Reset values
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_outputs", 64'({spi_miso, mem_req, mem_addr, busy, cmd_err, underrun}), 64'(0));
    reset = 1'b1;
    repeat (4) @(negedge clock);
    chk("idle_busy", 64'(busy), 64'(0));

    // Known word at 0x100, half-period 17, ack after 2 cycles
    lat = 2;
    spi_xfer(8'h03, 24'h000100, 24, 1, 17, -1);
    chk("deadbeef", 64'(rx_q[0]), 64'(32'hDEADBEEF));
    check_read("rd100", 24'h000100, 1, 1'b0);

    // Address wrap at top of the space
    spi_xfer(8'h03, 24'hFFFFFC, 24, 2, 8, -1);
    check_read("wrap", 24'hFFFFFC, 2, 1'b0);
    chk("wrap_second_fetch", 64'(fetch_q[1]), 64'(0));

    // Randomised reads (unaligned addresses exercise bit [1:0] masking)
    for (int t = 0; t < 4; t++) begin
      ra  = 24'($urandom);
      nw  = $urandom_range(1, 2);
      h   = $urandom_range(6, 10);
      lat = $urandom_range(1, 2);
      spi_xfer(8'h03, ra, 24, nw, h, -1);
      check_read($sformatf("rand%0d", t), ra, nw, 1'b0);
    end
    lat = 2;

    // Late first ack: underrun word is zeros, next word correct
    once_lat = 40;
    spi_xfer(8'h03, 24'h000200, 24, 2, 17, -1);
    check_read("underrun", 24'h000200, 2, 1'b1);

    // SS raised after 20 address bits, then a clean read
    spi_xfer(8'h03, 24'h123456, 20, 0, 8, -1);
    chk("abort_no_req", 64'(req_cycles), 64'(0));
    chk("abort_no_fetch", 64'(fetch_q.size()), 64'(0));
    ra = 24'($urandom);
    spi_xfer(8'h03, ra, 24, 1, 8, -1);
    check_read("after_abort", ra, 1, 1'b0);

    // Unsupported command
    spi_xfer(8'h0B, 24'h000100, 24, 1, 8, -1);
    exp_cmd_err = 1'b1;
    chk("badcmd_err", 64'(cmd_err), 64'(1));
    chk("badcmd_no_req", 64'(req_cycles), 64'(0));
    chk("badcmd_miso_pre", 64'(pre_nz), 64'(0));
    chk("badcmd_miso_data", 64'(rx_q[0]), 64'(0));

    // Reset in the middle of DATA, then read address 0
    spi_xfer(8'h03, 24'h000400, 24, 2, 8, 50);
    exp_cmd_err  = 1'b0;
    exp_underrun = 1'b0;
    spi_xfer(8'h03, 24'h000000, 24, 1, 8, -1);
    check_read("post_reset", 24'h000000, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
